// File: rtl/draw_pkg.sv
// Shared drawing constants for the 160x120 VGA square pipeline, plus the scanner FSM
// state type and the helper used to size counters.
package draw_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int SQUARE_SIZE = 4;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} scan_state_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_square_index.sv
// Lane/square cursor for the scanner: clears to (0,0), steps square-first, and flags
// the final cell of the grid.
module lane_square_index
  import draw_pkg::*;
#(
  parameter int NUM_LANES   = 3,
  parameter int NUM_SQUARES = 26,
  parameter int LW          = 2,
  parameter int SW          = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [LW-1:0] o_lane,
  output logic [SW-1:0] o_sq,
  output logic          o_last
);

  logic [LW-1:0] r_lane;
  logic [SW-1:0] r_sq;
  logic          w_sq_wrap;

  assign w_sq_wrap = (r_sq == SW'(NUM_SQUARES - 1));
  assign o_last    = w_sq_wrap && (r_lane == LW'(NUM_LANES - 1));
  assign o_lane    = r_lane;
  assign o_sq      = r_sq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane <= '0;
      r_sq   <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
      r_sq   <= '0;
    end else if (i_advance) begin
      if (o_last) begin
        r_lane <= '0;
        r_sq   <= '0;
      end else if (w_sq_wrap) begin
        r_sq   <= '0;
        r_lane <= r_lane + 1'b1;
      end else begin
        r_sq <= r_sq + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_square_scanner.sv
// Snapshots the lane shift registers on frame_start and issues one handshaked draw
// request per (lane, square) cell, optionally skipping cells unchanged since last frame.
module lane_square_scanner
  import draw_pkg::*;
#(
  parameter int NUM_LANES   = 3,
  parameter int NUM_SQUARES = 26,
  parameter int START_X     = 1,
  parameter int START_Y     = 53,
  parameter int X_OFFSET    = 5,
  parameter int Y_OFFSET    = 11,
  parameter logic [3*NUM_LANES-1:0] LANE_COLOURS = 9'b011110100
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES*NUM_SQUARES-1:0] lane_seq,
  input  logic                           frame_start,
  input  logic                           dirty_only,
  output logic                           draw_req,
  input  logic                           draw_ack,
  output logic [7:0]                     output_x,
  output logic [6:0]                     output_y,
  output logic [2:0]                     colour,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int NCELLS = NUM_LANES * NUM_SQUARES;
  localparam int LW     = idx_width(NUM_LANES);
  localparam int SW     = idx_width(NUM_SQUARES);
  localparam int CW     = idx_width(NCELLS);

  if (NUM_LANES < 1 || NUM_LANES > 8 || NUM_SQUARES < 1 || NUM_SQUARES > 32 ||
      START_X + X_OFFSET*(NUM_SQUARES-1) + SQUARE_SIZE-1 > SCREEN_W-1 ||
      START_Y + Y_OFFSET*(NUM_LANES-1) + SQUARE_SIZE-1 > SCREEN_H-1) begin : g_bad_geometry
    $error("lane_square_scanner: grid does not fit the 160x120 screen");
  end

  scan_state_t       r_state, w_state_next;
  logic [NCELLS-1:0] r_shadow, r_prev;
  logic              r_prev_valid, r_dirty_mode;
  logic              r_draw_req, r_busy, r_frame_done;
  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic [2:0]        r_colour;

  logic [LW-1:0]     w_lane;
  logic [SW-1:0]     w_sq;
  logic              w_last, w_clear, w_advance, w_skip, w_shadow_bit;
  logic [CW-1:0]     w_cell_idx;
  logic [7:0]        w_x;
  logic [6:0]        w_y;
  logic [2:0]        w_colour;

  lane_square_index #(
    .NUM_LANES  (NUM_LANES),
    .NUM_SQUARES(NUM_SQUARES),
    .LW         (LW),
    .SW         (SW)
  ) u_index (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_advance(w_advance),
    .o_lane   (w_lane),
    .o_sq     (w_sq),
    .o_last   (w_last)
  );

  assign w_cell_idx   = CW'(w_lane) * CW'(NUM_SQUARES) + CW'(w_sq);
  assign w_shadow_bit = r_shadow[w_cell_idx];
  assign w_skip       = r_dirty_mode & r_prev_valid & (w_shadow_bit == r_prev[w_cell_idx]);
  // Coordinates wrap in the output widths; the geometry check keeps them on screen.
  assign w_x          = 8'(START_X) + 8'(X_OFFSET) * 8'(w_sq);
  assign w_y          = 7'(START_Y) + 7'(Y_OFFSET) * 7'(w_lane);
  assign w_colour     = w_shadow_bit ? LANE_COLOURS[3*w_lane +: 3] : BLACK;

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_clear      = 1'b1;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        if (w_skip) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? DONE : SCAN;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (draw_ack) begin
          w_advance    = 1'b1;
          w_state_next = w_last ? DONE : SCAN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_dirty_mode <= 1'b0;
      r_draw_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_shadow     <= lane_seq;
            r_dirty_mode <= dirty_only;
            r_busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (!w_skip) begin
            r_x        <= w_x;
            r_y        <= w_y;
            r_colour   <= w_colour;
            r_draw_req <= 1'b1;
          end
        end
        WAIT: begin
          if (draw_ack) begin
            r_draw_req         <= 1'b0;
            r_prev[w_cell_idx] <= w_shadow_bit;
          end
        end
        DONE:    r_prev_valid <= 1'b1;
        default: ;
      endcase
      if (w_state_next == DONE) r_busy <= 1'b0;
    end
  end

  assign draw_req   = r_draw_req;
  assign output_x   = r_x;
  assign output_y   = r_y;
  assign colour     = r_colour;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
